// File: rtl/sram_mem_ctrl_if.sv
// Request/response and SRAM pad bundle between the MEM stage, the SRAM and sram_mem_ctrl.
// The controller binds to the slave modport; the CPU/SRAM side binds to the master modport.
interface sram_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [10:0] mem_addr_q;
    logic        stall;
    logic        done;
    logic [10:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, sram_dq_in,
        input  mem_rdata, mem_addr_q, stall, done,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, sram_dq_in,
        output mem_rdata, mem_addr_q, stall, done,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller running wait-stated loads/stores on a 16-bit async SRAM.
// Define MEMCTRL_FWD_EN to add a one-entry store buffer that forwards matching loads.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [10:0] addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] rdata_reg;
    logic        done_reg;
    logic        ce_n_reg;
    logic        oe_n_reg;
    logic        we_n_reg;
    logic        dq_oe_reg;

    logic        fwd_hit;
    logic [15:0] fwd_data;

`ifdef MEMCTRL_FWD_EN
    logic        fwd_valid_reg;
    logic [10:0] fwd_addr_reg;
    logic [15:0] fwd_data_reg;

    // The buffer mirrors the most recently accepted store; write beats read when both are asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_valid_reg <= 1'b0;
            fwd_addr_reg  <= '0;
            fwd_data_reg  <= '0;
        end else if (state_reg == IDLE && bus.mem_write) begin
            fwd_valid_reg <= 1'b1;
            fwd_addr_reg  <= bus.mem_addr;
            fwd_data_reg  <= bus.mem_wdata;
        end
    end

    assign fwd_hit  = fwd_valid_reg && (bus.mem_addr == fwd_addr_reg);
    assign fwd_data = fwd_data_reg;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            done_reg     <= 1'b0;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            dq_oe_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.mem_write) begin
                        addr_reg  <= bus.mem_addr;
                        wdata_reg <= bus.mem_wdata;
                        ce_n_reg  <= 1'b0;
                        dq_oe_reg <= 1'b1;
                        state_reg <= WR_SETUP;
                    end else if (bus.mem_read) begin
                        addr_reg <= bus.mem_addr;
                        if (fwd_hit) begin
                            rdata_reg <= fwd_data;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            ce_n_reg     <= 1'b0;
                            oe_n_reg     <= 1'b0;
                            wait_cnt_reg <= WAIT_LAST;
                            state_reg    <= RD_ACCESS;
                        end
                    end
                end

                RD_ACCESS: begin
                    if (wait_cnt_reg == 4'd0) begin
                        rdata_reg <= bus.sram_dq_in;
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end

                // Address and data settle for a cycle before we_n falls.
                WR_SETUP: begin
                    we_n_reg     <= 1'b0;
                    wait_cnt_reg <= WAIT_LAST;
                    state_reg    <= WR_PULSE;
                end

                WR_PULSE: begin
                    if (wait_cnt_reg == 4'd0) begin
                        we_n_reg  <= 1'b1;
                        state_reg <= WR_HOLD;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end

                WR_HOLD: begin
                    ce_n_reg  <= 1'b1;
                    dq_oe_reg <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    ce_n_reg  <= 1'b1;
                    oe_n_reg  <= 1'b1;
                    we_n_reg  <= 1'b1;
                    dq_oe_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the acceptance cycle itself, so it looks at the live request.
    assign bus.stall = rst_n &&
                       ((state_reg == IDLE && (bus.mem_read || bus.mem_write)) ||
                        (state_reg != IDLE && state_reg != DONE));

    assign bus.done        = done_reg;
    assign bus.mem_rdata   = rdata_reg;
    assign bus.mem_addr_q  = addr_reg;
    assign bus.sram_addr   = addr_reg;
    assign bus.sram_dq_out = wdata_reg;
    assign bus.sram_dq_oe  = dq_oe_reg;
    assign bus.sram_ce_n   = ce_n_reg;
    assign bus.sram_oe_n   = oe_n_reg;
    assign bus.sram_we_n   = we_n_reg;

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

MEM-stage data-memory access controller for the 32-bit pipelined CPU. It accepts one load or store per request from the MEM stage and runs a multi-cycle, wait-stated access on the 16-bit asynchronous data SRAM. While the access is in progress it stalls the pipeline. It presents the captured 16-bit read word and its word address to the downstream SRAM sign-extension stage, which widens the word to 32 bits.

## Interface
Parameters:
- WAIT_CYCLES, 2: SRAM access/strobe width in clocks; legal range 1–15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- mem_read  in  1  load request from the MEM stage.
- mem_write  in  1  store request from the MEM stage; wins if asserted together with mem_read.
- mem_addr  in  11  word address.
- mem_wdata  in  16  store data.
- mem_rdata  out  16  captured load word; feeds the sign extender's data input.
- mem_addr_q  out  11  latched address of the current or last access; feeds the sign extender's address input.
- stall  out  1  freezes the pipeline while high.
- done  out  1  one-cycle pulse when an access completes.
- sram_addr  out  11  SRAM address bus.
- sram_dq_out  out  16  write data to the SRAM data pads.
- sram_dq_oe  out  1  data-pad drive enable.
- sram_dq_in  in  16  read data from the SRAM data pads.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

## Operation
The FSM has states IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD and DONE. A wait counter is 4 bits wide.

- **IDLE:** all strobes high; sram_dq_oe=0.
  - mem_write: latch mem_addr into addr_q and mem_wdata into wdata_q, then go to WR_SETUP.
  - else mem_read: latch addr_q, then go to RD_ACCESS.
- **RD_ACCESS:** ce_n=0 and oe_n=0 for WAIT_CYCLES cycles. On the last cycle's edge, capture sram_dq_in into mem_rdata, then go to DONE.
- **WR_SETUP:** 1 cycle; ce_n=0, dq_oe=1, we_n=1.
- **WR_PULSE:** WAIT_CYCLES cycles; ce_n=0, we_n=0, dq_oe=1.
- **WR_HOLD:** 1 cycle; ce_n=0, we_n=1, dq_oe=1. Data and address stay stable through this cycle.
- **DONE:** 1 cycle; strobes high; done=1. Always returns to IDLE. Requests present in DONE are ignored, because the pipeline advances on this cycle.

Output behaviour:
- stall = rst_n & ((state==IDLE & (mem_read|mem_write)) | (state!=IDLE & state!=DONE)). It is combinational.
- sram_addr = mem_addr_q = addr_q. sram_dq_out = wdata_q.
- mem_rdata changes only on a read capture (or a forward hit). It holds its value across writes and idle cycles.
- All 11-bit addresses are legal. Region decoding is done downstream.
- Request inputs are sampled only in IDLE. Changes to them during an access are ignored.

Reset:
- Reset is checked at every edge and wins over all other transitions.
- An access in progress is abandoned. we_n deasserts at that same edge, so no partial write continues.

Reset values:
- state = IDLE.
- mem_rdata = 0; addr_q = 0; wdata_q = 0.
- done = 0; stall = 0.
- sram_ce_n, sram_oe_n, sram_we_n = 1.
- sram_dq_oe = 0.
- Forward buffer invalid.

## Timing
Cycle 0 is the cycle in which the request is accepted in IDLE.
- **Load:** stall is high for cycles 0..W. DONE occurs at cycle W+1. mem_rdata is valid from cycle W+1.
- **Store:** stall is high for cycles 0..W+2. DONE occurs at cycle W+3. we_n is low exactly W cycles.
- **Back-to-back accesses:** the earliest next acceptance is the cycle after DONE.
- The SRAM is never driven (dq_oe=1) while oe_n=0.

## Configuration
- **MEMCTRL_FWD_EN defined:**
  - A one-entry store buffer (fwd_valid, fwd_addr, fwd_data) is loaded when each store is accepted.
  - A load accepted in IDLE with fwd_valid and mem_addr==fwd_addr skips the SRAM: mem_rdata is loaded from fwd_data at that edge, and the FSM goes to DONE.
  - A forwarded load stalls 1 cycle, with DONE at cycle 1, and issues no SRAM strobes.
  - fwd_valid is cleared on reset.
- **MEMCTRL_FWD_EN undefined:** no buffer logic exists, and every load takes the full SRAM path.

## Test plan
With WAIT_CYCLES=2:
1. **Reset mid-read:** rst_n=0 for 1 cycle during RD_ACCESS -> next cycle shows state IDLE, all strobes 1, mem_rdata=0, stall=0, done=0.
2. **Store:** addr 3, data 0x8001 -> stall high for cycles 0–4; we_n low for exactly 2 cycles; dq_oe=1 for cycles 1–4; done pulses at cycle 5; the SRAM model holds 0x8001 at address 3.
3. **Load:** load addr 3 (SRAM model returns 0x8001) -> ce_n and oe_n low for 2 cycles; mem_rdata=0x8001 and mem_addr_q=3 at cycle 3; done pulses at cycle 3; stall is low at cycle 3.
4. **Simultaneous read and write:** mem_read=mem_write=1, addr 7, data 0x1234 -> a write cycle runs, with no oe_n pulse; mem_rdata is unchanged.
5. **Back-to-back loads:** loads to addr 5 then addr 6 with the request held -> the second is accepted the cycle after the first DONE; the two accesses do not overlap; done gives two separate single-cycle pulses.
6. **Forward hit (FWD_EN only):** store addr 4 = 0xBEEF, then load addr 4 -> mem_rdata=0xBEEF at cycle 1, no strobe activity, stall high for 1 cycle only. A load to addr 2 instead takes the normal 3-cycle path.
